// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port DataMem arbiter.
//   state_e          : sequencer state encoding
//   RD_WAIT_DEFAULT  : default number of cycles Mem_rd is held before capture
//   CNT_W            : width of the read-settle counter (covers RD_WAIT up to 15)
//   pick_winner()    : round-robin winner select for two requesters
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam int RD_WAIT_DEFAULT = 1;
  localparam int CNT_W           = 4;

  // Single requester wins outright; on a tie the port named by prio wins.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic prio);
    logic w;
    if (r0 && r1) w = prio;
    else          w = r1;
    return w;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported DataMem
// (asynchronous read, negedge write). Port 0 is the CPU load/store path,
// port 1 a secondary master. Requests are sampled only in IDLE, the winning
// transaction is latched, reads are held for RD_WAIT cycles before Mem_DOUT
// is captured, and writes get exactly one cycle of Mem_wr.
//
// state | meaning
// IDLE  | sample requests, latch winner's address/data
// RD    | Mem_rd high, count down read settle time, capture on terminal count
// WR    | Mem_wr high for one cycle; DataMem commits on the negedge inside it
// ACK   | one-cycle ack to the owner; priority passes to the other port
//
// Ports:
//   CLK, Reset                      clock (rising edge), async active-high reset
//   req/wr/addr/wdata 0,1           requester inputs, held stable until ack
//   rdata0/1, ack0/1                registered read data, one-cycle completion
//   busy, gnt_id                    not-IDLE flag, owner of current/last transaction
//   Mem_Addr/Mem_DIN/Mem_rd/Mem_wr  DataMem interface, Mem_DOUT its read data
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int RD_WAIT  = RD_WAIT_DEFAULT
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                req0,
  input  logic                wr0,
  input  logic [WordSize-1:0] addr0,
  input  logic [WordSize-1:0] wdata0,
  output logic [WordSize-1:0] rdata0,
  output logic                ack0,
  input  logic                req1,
  input  logic                wr1,
  input  logic [WordSize-1:0] addr1,
  input  logic [WordSize-1:0] wdata1,
  output logic [WordSize-1:0] rdata1,
  output logic                ack1,
  output logic                busy,
  output logic                gnt_id,
  output logic [WordSize-1:0] Mem_Addr,
  output logic                Mem_rd,
  output logic                Mem_wr,
  output logic [WordSize-1:0] Mem_DIN,
  input  logic [WordSize-1:0] Mem_DOUT
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prio_q, prio_d;
  logic                gnt_q, gnt_d;
  logic [WordSize-1:0] addr_q, addr_d;
  logic [WordSize-1:0] din_q, din_d;
  logic [WordSize-1:0] rdata0_q, rdata0_d;
  logic [WordSize-1:0] rdata1_q, rdata1_d;
  logic                win;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win    = pick_winner(req0, req1, prio_q);
          gnt_d  = win;
          addr_d = win ? addr1 : addr0;
          din_d  = win ? wdata1 : wdata0;
          if (win ? wr1 : wr0) begin
            state_d = WR;
          end else begin
            state_d = RD;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (gnt_q) rdata1_d = Mem_DOUT;
          else       rdata0_d = Mem_DOUT;
          state_d = ACK;
        end
      end
      WR: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        prio_d  = ~gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes decode from the state register only, so reset drops Mem_wr at
  // once (aborting a write before its negedge) and rd/wr can never overlap.
  assign Mem_rd   = (state_q == RD);
  assign Mem_wr   = (state_q == WR);
  assign busy     = (state_q != IDLE);
  assign ack0     = (state_q == ACK) && !gnt_q;
  assign ack1     = (state_q == ACK) &&  gnt_q;
  assign gnt_id   = gnt_q;
  assign Mem_Addr = addr_q;
  assign Mem_DIN  = din_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int          TB_RD_WAIT = 3;
  localparam logic [31:0] POISON     = 32'hBAD0_BAD0;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [31:0] rdata0, rdata1, Mem_Addr, Mem_DIN;
  logic [31:0] Mem_DOUT = POISON;
  logic        ack0, ack1, busy, gnt_id, Mem_rd, Mem_wr;

  dmem_arbiter #(.WordSize(32), .RD_WAIT(TB_RD_WAIT)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .busy(busy), .gnt_id(gnt_id),
    .Mem_Addr(Mem_Addr), .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Mem_DIN(Mem_DIN), .Mem_DOUT(Mem_DOUT)
  );

  always #10ns CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int ack1_cnt = 0;
  int grant_log[$];

  logic [31:0] dmem   [256];
  logic [31:0] refmem [256];

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // DataMem: negedge write, asynchronous read that settles 50 ns after
  // address/strobe change; poison value while unsettled.
  always @(negedge CLK) if (Mem_wr) dmem[Mem_Addr[9:2]] = Mem_DIN;

  always @(Mem_Addr or Mem_rd) begin
    Mem_DOUT <= POISON;
    if (Mem_rd) Mem_DOUT <= #50ns dmem[Mem_Addr[9:2]];
  end

  // Behavioural model: a transaction occupies `len` cycles after the edge
  // that sampled it (write 2, read RD_WAIT+1); the last of them is the ack
  // cycle, then one idle cycle follows before the next sample.
  int          t_m = 0, len_m = 0;
  bit          wr_m = 0, own_m = 0, prio_m = 0;
  logic [31:0] addr_m = '0, din_m = '0, rd0_m = '0, rd1_m = '0;

  always begin
    @(posedge CLK or posedge Reset);
    if (Reset) begin
      t_m = 0; len_m = 0; wr_m = 0; own_m = 0; prio_m = 0;
      addr_m = '0; din_m = '0; rd0_m = '0; rd1_m = '0;
    end else begin
      cyc++;
      if (t_m == 0) begin
        if (req0 || req1) begin
          own_m  = (req0 && req1) ? prio_m : req1;
          wr_m   = own_m ? wr1 : wr0;
          addr_m = own_m ? addr1 : addr0;
          din_m  = own_m ? wdata1 : wdata0;
          len_m  = wr_m ? 2 : TB_RD_WAIT + 1;
          t_m    = 1;
          grant_log.push_back(int'(own_m));
        end
      end else if (t_m == len_m) begin
        t_m    = 0;
        prio_m = !own_m;
      end else begin
        if (wr_m && t_m == 1) refmem[addr_m[9:2]] = din_m;
        t_m++;
        if (!wr_m && t_m == len_m) begin
          if (own_m) rd1_m = refmem[addr_m[9:2]];
          else       rd0_m = refmem[addr_m[9:2]];
        end
      end
    end
    #2ns;
    chk1("busy",     busy,   t_m != 0);
    chk1("ack0",     ack0,   t_m != 0 && t_m == len_m && !own_m);
    chk1("ack1",     ack1,   t_m != 0 && t_m == len_m &&  own_m);
    chk1("Mem_wr",   Mem_wr, t_m == 1 && wr_m);
    chk1("Mem_rd",   Mem_rd, t_m != 0 && !wr_m && t_m < len_m);
    chk1("rd_wr_excl", Mem_rd & Mem_wr, 1'b0);
    chk1("gnt_id",   gnt_id, own_m);
    chk("Mem_Addr",  Mem_Addr, addr_m);
    chk("Mem_DIN",   Mem_DIN,  din_m);
    chk("rdata0",    rdata0,   rd0_m);
    chk("rdata1",    rdata1,   rd1_m);
    if (Mem_wr) wr_cnt++;
    if (ack1)   ack1_cnt++;
  end

  task automatic do_txn(input bit port, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit keep, output int lat);
    bit got;
    got = 0;
    @(negedge CLK);
    if (port) begin req1 = 1; wr1 = wr; addr1 = addr; wdata1 = data; end
    else      begin req0 = 1; wr0 = wr; addr0 = addr; wdata0 = data; end
    lat = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge CLK);
      #2ns;
      lat++;
      got = port ? ack1 : ack0;
    end
    chk1("ack_seen", got, 1'b1);
    if (!keep) begin
      if (port) req1 = 0;
      else      req0 = 0;
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge CLK);
    #2ns;
  endtask

  int lat, lat_a, lat_b, c0, a1, w0;
  int exp_order[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    #100us;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]   = init_val(i);
      refmem[i] = init_val(i);
    end
    Reset = 1;
    repeat (3) @(negedge CLK);
    Reset = 0;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_gnt", gnt_id, 1'b0);
    chk("rst_addr", Mem_Addr, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);

    // write then read back on port 0
    w0 = wr_cnt;
    do_txn(0, 1, 32'h10, 32'hDEAD_BEEF, 0, lat);
    chk("t1_wr_lat", lat, 2);
    chk("t1_wr_pulse", wr_cnt - w0, 1);
    chk("t1_mem", dmem[4], 32'hDEAD_BEEF);
    settle();
    do_txn(0, 0, 32'h10, 32'h0, 0, lat);
    chk("t1_rd_lat", lat, TB_RD_WAIT + 1);
    chk("t1_rdata0", rdata0, 32'hDEAD_BEEF);

    // port 1 read so priority returns to port 0
    settle();
    do_txn(1, 0, 32'h0, 32'h0, 0, lat);
    chk("t1_rdata1", rdata1, 32'hA500_0000);

    // simultaneous reads with prio=0
    settle();
    grant_log.delete();
    fork
      do_txn(0, 0, 32'h20, 32'h0, 0, lat_a);
      do_txn(1, 0, 32'h24, 32'h0, 0, lat_b);
    join
    chk("t2_lat0", lat_a, 4);
    chk("t2_lat1", lat_b, 9);
    chk("t2_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first", grant_log[0], 0);
      chk("t2_second", grant_log[1], 1);
    end
    chk("t2_rdata0", rdata0, 32'hA500_0008);
    chk("t2_rdata1", rdata1, 32'hA500_0009);

    // both ports hold req for three writes each
    settle();
    grant_log.delete();
    c0 = cyc;
    fork
      begin
        int la;
        for (int k = 0; k < 3; k++) do_txn(0, 1, 32'h100 + 32'(8 * k), 32'h1000 + 32'(k), k < 2, la);
      end
      begin
        int lb;
        for (int k = 0; k < 3; k++) do_txn(1, 1, 32'h104 + 32'(8 * k), 32'h2000 + 32'(k), k < 2, lb);
      end
    join
    chk("t3_cycles", cyc - c0, 17);
    chk("t3_ngrant", grant_log.size(), 6);
    if (grant_log.size() == 6)
      for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d", k), grant_log[k], exp_order[k]);
    chk("t3_mem_p1", dmem[69], 32'h2002);
    chk("t3_mem_p0", dmem[68], 32'h1002);

    // reset during a port 1 write, before the WR negedge
    settle();
    a1 = ack1_cnt;
    @(negedge CLK);
    req1 = 1; wr1 = 1; addr1 = 32'h30; wdata1 = 32'h5555_AAAA;
    @(posedge CLK);
    #3ns;
    Reset = 1;
    #2ns;
    chk1("t5_memwr", Mem_wr, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_ack1", ack1, 1'b0);
    chk("t5_addr", Mem_Addr, 32'h0);
    chk("t5_din", Mem_DIN, 32'h0);
    chk("t5_rdata1", rdata1, 32'h0);
    @(negedge CLK);
    req1 = 0;
    repeat (2) @(negedge CLK);
    Reset = 0;
    chk("t5_mem30", dmem[12], 32'hA500_000C);
    chk("t5_noack", ack1_cnt - a1, 0);
    grant_log.delete();
    fork
      do_txn(0, 0, 32'h20, 32'h0, 0, lat_a);
      do_txn(1, 0, 32'h24, 32'h0, 0, lat_b);
    join
    chk("t5_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) chk("t5_prio0", grant_log[0], 0);
    chk("t5_rdata1", rdata1, 32'hA500_0009);

    // rdata isolation between ports and writes
    settle();
    do_txn(0, 1, 32'h40, 32'h1234, 0, lat);
    settle();
    do_txn(0, 0, 32'h40, 32'h0, 0, lat);
    chk("t6_rdata0", rdata0, 32'h1234);
    settle();
    do_txn(1, 1, 32'h40, 32'hCAFE_F00D, 0, lat);
    chk("t6_keep0", rdata0, 32'h1234);
    chk("t6_keep1", rdata1, 32'hA500_0009);
    settle();
    do_txn(1, 0, 32'h40, 32'h0, 0, lat);
    chk("t6_rdata1", rdata1, 32'hCAFE_F00D);
    chk("t6_still0", rdata0, 32'h1234);

    settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported DataMem (asynchronous read, negedge-CLK write, no simultaneous read/write). It shares the memory between port 0, the CPU load/store path, and port 1, a secondary master such as a debug or DMA loader. It uses round-robin priority, latches each transaction, and times read settling and write commit. It also guarantees that Mem_rd and Mem_wr are never both asserted.

Parameters:
WordSize, 32, data and address width
RD_WAIT, 1, CLK cycles Mem_rd is held before Mem_DOUT is captured (RD_WAIT*Tclk must exceed memory T_rd); legal range 1..15

Ports:
CLK  input  1  system clock, rising-edge logic
Reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 request; held until ack0
wr0  input  1  port 0: 1=write, 0=read
addr0  input  WordSize  port 0 byte address
wdata0  input  WordSize  port 0 write data
rdata0  output  WordSize  port 0 read data, registered
ack0  output  1  port 0 completion pulse, one cycle
req1, wr1, addr1, wdata1, rdata1, ack1  as port 0, for port 1
busy  output  1  high when state != IDLE
gnt_id  output  1  port owning the current or last transaction
Mem_Addr  output  WordSize  to DataMem, registered
Mem_rd  output  1  to DataMem
Mem_wr  output  1  to DataMem
Mem_DIN  output  WordSize  to DataMem, registered
Mem_DOUT  input  WordSize  from DataMem

Behaviour:
- Reset (async, immediate): state=IDLE; Mem_rd=Mem_wr=0; Mem_Addr=Mem_DIN=0; rdata0=rdata1=0; ack0=ack1=0; busy=0; gnt_id=0; priority pointer prio=0; wait counter cnt=0.
- States: IDLE, RD, WR, ACK.
- IDLE: requests are sampled only in this state.
  - Winner: if only one req is set, that port wins; if both, the port == prio wins.
  - At the posedge: latch Mem_Addr, Mem_DIN and gnt_id from the winner. Go to WR if its wr=1; otherwise go to RD with cnt=RD_WAIT-1.
  - With no req, the state stays IDLE and Mem_Addr/Mem_DIN hold their last values.
- WR (exactly 1 cycle): Mem_wr=1 for the whole cycle, so the DataMem negedge inside it commits the write. Next posedge goes to ACK.
- RD: Mem_rd=1. At a posedge with cnt!=0, decrement cnt. At a posedge with cnt==0, capture Mem_DOUT into rdata[gnt_id] and go to ACK.
- ACK (1 cycle): ack[gnt_id]=1 and Mem_rd=Mem_wr=0. Next posedge goes to IDLE with prio = ~gnt_id.
- Outputs decode from registered state only. Mem_rd=1 only in RD and Mem_wr=1 only in WR, so they are mutually exclusive by construction.
- Latency from the req-sampling edge to the ack cycle: write = 2 cycles; read = RD_WAIT+1 cycles.
- Throughput: one transaction per (latency+1) cycles, because IDLE is always revisited.
- rdataN holds until the next read completes on port N. Writes and the other port never alter it.
- A requester keeps reqN, wrN, addrN and wdataN stable until ackN. If reqN is still high at the IDLE after ACK, it is a new transaction. Because of round-robin, a continuously requesting port alternates with the other port and cannot starve it.
- Input changes outside IDLE are ignored, since the transaction is latched.
- Addresses pass unmodified; DataMem drops bits [1:0].
- Reset mid-WR before the negedge: Mem_wr drops asynchronously and the write is aborted. Reset after the negedge: the write stands. No ack is issued for an aborted transaction in either case.

Decomposition:
- Shared package/header holds the state encodings (IDLE=2'd0, RD=2'd1, WR=2'd2, ACK=2'd3) and the RD_WAIT default.
- A single module with no sub-module is required. The winner-select logic is a small combinational function.

Test Plan:
1. req0=1, wr0=1, addr0=0x10, wdata0=0xDEADBEEF -> Mem_wr high for exactly 1 cycle with Mem_Addr=0x10, ack0 pulses 2 cycles after the sampling edge; then a read of 0x10 on port 0 -> rdata0=0xDEADBEEF with ack0 at RD_WAIT+1 cycles; Mem_rd and Mem_wr never both high.
2. req0 and req1 rise together (reads of 0x20 and 0x24) with prio=0 -> port 0 is served first, gnt_id=0; port 1 is served next, gnt_id=1; each ack is exactly one cycle.
3. Both ports hold req high for 6 transactions -> grants alternate 0,1,0,1,0,1; busy drops for exactly 1 cycle between transactions.
4. RD_WAIT=3, Mem_DOUT model with T_rd=50 ns and CLK period 20 ns -> correct data captured 4 cycles after the sampling edge.
5. Port 1 write to 0x30 in flight, Reset asserted before the WR negedge -> Mem_wr falls immediately, memory word 0x30 is unchanged, no ack1, all outputs at reset values, prio=0.
6. Port 0 read of 0x40 completes with 0x1234; port 1 then writes 0x40 -> rdata0 stays 0x1234 and rdata1 stays unchanged.
